// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- IF-stage PC / instruction fetch engine.
//
// Owns the PC and runs a single-outstanding instruction-bus handshake. The
// fetched {pc_o, inst_o} pair goes to the IF/ID register. stallreq_o asks
// ctrl to stall while a fetch is still waiting for its ack.
//
// Parameters:
//   RESET_PC  PC value after reset
//   PC_STEP   sequential PC increment in bytes
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall[5:0]          ctrl stall vector; bit1 = IF, bit2 = ID
//   flush, new_pc       ctrl exception flush and redirect target
//   branch_flag_i       ID branch/jump taken
//   branch_target_i     ID branch/jump target
//   ibus_req_o          instruction-bus request
//   ibus_addr_o         instruction-bus address (word aligned)
//   ibus_ack_i          bus ack; ibus_data_i is valid in the same cycle
//   ibus_data_i         instruction word
//   pc_o, inst_o        fetched PC / instruction (inst_o = 0 when not valid)
//   inst_valid_o        inst_o holds a real fetch result
//   adel_o              fetch address-error flag
//   stallreq_o          pc stall request to ctrl
//
// Build option:
//   FETCH_ADEL_EN  a misaligned PC skips the bus and completes at once
//                  with inst_o = 0 and adel_o = 1.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        adel_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_buf, inst_buf_n;
  logic [31:0] drain_addr, drain_addr_n;
  logic [31:0] br_tgt, br_tgt_n;
  logic        br_pend, br_pend_n;

  logic        is_fetch, is_hold, is_drain;
  logic        misalign;
  logic        fetch_ack;
  logic        consume;
  logic [31:0] next_seq;

  assign is_fetch = (state == S_FETCH);
  assign is_hold  = (state == S_HOLD);
  assign is_drain = (state == S_DRAIN);

`ifdef FETCH_ADEL_EN
  logic adel_buf, adel_buf_n;
  assign misalign = is_fetch & (pc[1:0] != 2'b00);
  // The HOLD copy of the error flag keeps adel_o attached to its zero word.
  assign adel_o   = misalign | (is_hold & adel_buf);
`else
  assign misalign = 1'b0;
  assign adel_o   = 1'b0;
`endif

  // A misaligned fetch completes immediately without touching the bus.
  assign fetch_ack    = is_fetch & (ibus_ack_i | misalign);
  assign ibus_req_o   = is_drain | (is_fetch & ~misalign);
  assign ibus_addr_o  = is_drain ? {drain_addr[31:2], 2'b00} : {pc[31:2], 2'b00};
  assign pc_o         = pc;
  assign inst_valid_o = is_hold | fetch_ack;
  assign inst_o       = is_hold ? inst_buf
                      : ((fetch_ack & ~misalign) ? ibus_data_i : '0);
  assign stallreq_o   = (is_fetch & ~fetch_ack) | is_drain;

  // Same-cycle hand-off to IF/ID when IF is not stalled (zero bubble).
  assign consume  = inst_valid_o & ~stall[1] & ~flush;
  assign next_seq = br_pend       ? br_tgt
                  : branch_flag_i ? branch_target_i
                  : pc + PC_STEP;

  logic unused_bits;
  assign unused_bits = ^{stall[5:3], stall[0], drain_addr[1:0]};

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_buf_n   = inst_buf;
    drain_addr_n = drain_addr;
    br_pend_n    = br_pend;
    br_tgt_n     = br_tgt;
`ifdef FETCH_ADEL_EN
    adel_buf_n   = adel_buf;
`endif

    if (flush) begin
      pc_n = new_pc;
      if (is_fetch & ~fetch_ack) begin
        state_n      = S_DRAIN;
        drain_addr_n = pc;
      end else if (is_drain & ~ibus_ack_i) begin
        // Old fetch still outstanding: keep draining the original address.
        state_n = S_DRAIN;
      end else begin
        state_n = S_FETCH;
      end
    end else if (is_drain & ibus_ack_i) begin
      state_n = S_FETCH;
    end else if (fetch_ack & stall[1]) begin
      state_n    = S_HOLD;
      inst_buf_n = inst_o;
`ifdef FETCH_ADEL_EN
      adel_buf_n = misalign;
`endif
    end else if (consume) begin
      state_n = S_FETCH;
      pc_n    = next_seq;
    end

    // Branch resolved while its delay slot is not yet consumed: remember it
    // so the delay slot is fetched first and the target afterwards.
    if (flush | consume) begin
      br_pend_n = 1'b0;
    end else if (branch_flag_i & ~stall[2]) begin
      br_pend_n = 1'b1;
      br_tgt_n  = branch_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      inst_buf   <= '0;
      drain_addr <= '0;
      br_pend    <= 1'b0;
      br_tgt     <= '0;
`ifdef FETCH_ADEL_EN
      adel_buf   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst_buf   <= inst_buf_n;
      drain_addr <= drain_addr_n;
      br_pend    <= br_pend_n;
      br_tgt     <= br_tgt_n;
`ifdef FETCH_ADEL_EN
      adel_buf   <= adel_buf_n;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit -- self-checking bench for if_fetch_unit: directed
// scenarios followed by randomized stimulus checked every cycle against a
// behavioural model of the fetch engine.
module tb_if_fetch_unit;

`ifdef FETCH_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        adel_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'hBFC00000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_ack_i(ibus_ack_i), .ibus_data_i(ibus_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .adel_o(adel_o), .stallreq_o(stallreq_o)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural view: a PC, an optional buffered instruction waiting for IF,
  // and an optional abandoned fetch whose ack must still be absorbed.
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_buf, m_drain_addr, m_br_tgt;
  bit          m_held, m_draining, m_br_pend, m_buf_adel;

  bit          e_fetching, e_mis, e_got, e_req, e_valid, e_stallreq, e_adel;
  logic [31:0] e_addr, e_inst;

  task automatic eval_model();
    e_fetching = !m_held && !m_draining;
    e_mis      = ADEL && e_fetching && (m_pc[1:0] != 2'b00);
    e_got      = e_fetching && (ibus_ack_i || e_mis);
    e_req      = m_draining || (e_fetching && !e_mis);
    e_addr     = (m_draining ? m_drain_addr : m_pc) & 32'hFFFF_FFFC;
    e_valid    = m_held || e_got;
    e_inst     = m_held ? m_buf : ((e_got && !e_mis) ? ibus_data_i : 32'h0);
    e_stallreq = (e_fetching && !e_got) || m_draining;
    e_adel     = e_mis || (ADEL && m_held && m_buf_adel);
  endtask

  task automatic drive(input bit r, input logic [5:0] st, input bit fl,
                       input logic [31:0] npc, input bit bf, input logic [31:0] bt,
                       input bit ak, input logic [31:0] dat);
    rst = r; stall = st; flush = fl; new_pc = npc;
    branch_flag_i = bf; branch_target_i = bt;
    ibus_ack_i = ak; ibus_data_i = dat;
    #1;
    if (m_known) begin
      eval_model();
      check_eq("m_req",      32'(ibus_req_o),   32'(e_req));
      if (e_req) check_eq("m_addr", ibus_addr_o, e_addr);
      check_eq("m_pc",       pc_o,              m_pc);
      check_eq("m_valid",    32'(inst_valid_o), 32'(e_valid));
      check_eq("m_inst",     inst_o,            e_inst);
      check_eq("m_stallreq", 32'(stallreq_o),   32'(e_stallreq));
      check_eq("m_adel",     32'(adel_o),       32'(e_adel));
    end
  endtask

  task automatic tick();
    bit          take;
    logic [31:0] nxt;
    eval_model();
    take = e_valid && !stall[1] && !flush;
    nxt  = m_br_pend ? m_br_tgt : (branch_flag_i ? branch_target_i : m_pc + 32'd4);
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1; m_pc = 32'hBFC00000; m_buf = '0; m_drain_addr = '0;
      m_br_tgt = '0; m_held = 0; m_draining = 0; m_br_pend = 0; m_buf_adel = 0;
    end else if (m_known) begin
      if (flush) begin
        if (e_fetching && !e_got) begin
          m_draining = 1; m_drain_addr = m_pc;
        end else if (!(m_draining && !ibus_ack_i)) begin
          m_draining = 0; m_held = 0;
        end
        m_pc = new_pc;
      end else if (m_draining && ibus_ack_i) begin
        m_draining = 0;
      end else if (e_got && stall[1]) begin
        m_held = 1; m_buf = e_inst; m_buf_adel = e_mis;
      end else if (take) begin
        m_held = 0; m_pc = nxt;
      end
      if (flush || take) m_br_pend = 0;
      else if (branch_flag_i && !stall[2]) begin
        m_br_pend = 1; m_br_tgt = branch_target_i;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    case ($urandom_range(0, 9))
      0:       return 32'hFFFF_FFFC;
      1:       return a;
      default: return a & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    logic [2:0] hi;
    bit r, fl, bf, ak;
    logic [5:0] st;
    logic [31:0] npc, bt, dat;

    rst = 1; stall = '0; flush = 0; new_pc = '0; branch_flag_i = 0;
    branch_target_i = '0; ibus_ack_i = 0; ibus_data_i = '0;
    @(negedge clk);
    drive(1, 6'd0, 0, 0, 0, 0, 0, 0); tick();

    // Reset state and first fetch acked on the third cycle
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_req", 32'(ibus_req_o), 1);
    check_eq("rst_addr", ibus_addr_o, 32'hBFC00000);
    check_eq("rst_valid", 32'(inst_valid_o), 0);
    check_eq("rst_inst", inst_o, 0);
    check_eq("rst_adel", 32'(adel_o), 0);
    check_eq("t1_sreq0", 32'(stallreq_o), 1);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_sreq1", 32'(stallreq_o), 1);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 1, 32'h24010001);
    check_eq("t1_sreq2", 32'(stallreq_o), 0);
    check_eq("t1_valid", 32'(inst_valid_o), 1);
    check_eq("t1_pc", pc_o, 32'hBFC00000);
    check_eq("t1_inst", inst_o, 32'h24010001);
    tick();

    // Ack under stall -> HOLD, then consumed when stall drops
    drive(0, 6'b000111, 0, 0, 0, 0, 1, 32'h24010001);
    check_eq("t1_next", ibus_addr_o, 32'hBFC00004);
    tick();
    drive(0, 6'b000111, 0, 0, 0, 0, 0, 32'h11111111);
    check_eq("t2_req", 32'(ibus_req_o), 0);
    check_eq("t2_inst", inst_o, 32'h24010001);
    check_eq("t2_pc", pc_o, 32'hBFC00004);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 32'h22222222);
    check_eq("t2_inst2", inst_o, 32'h24010001);
    check_eq("t2_valid", 32'(inst_valid_o), 1);
    tick();

    // Branch during delay-slot fetch: delay slot first, then target
    drive(0, 6'd0, 0, 0, 1, 32'h80001000, 0, 0);
    check_eq("t3_addr", ibus_addr_o, 32'hBFC00008);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 6'd0, 0, 0, 0, 0, 1, 32'h00000021);
    check_eq("t3_pc", pc_o, 32'hBFC00008);
    check_eq("t3_valid", 32'(inst_valid_o), 1);
    tick();

    // Flush during an unacked fetch -> DRAIN
    drive(0, 6'd0, 1, 32'h80000180, 0, 0, 0, 0);
    check_eq("t3_tgt", ibus_addr_o, 32'h80001000);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_addr", ibus_addr_o, 32'h80001000);
    check_eq("t4_sreq", 32'(stallreq_o), 1);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    check_eq("t4_drop", 32'(inst_valid_o), 0);
    check_eq("t4_inst", inst_o, 0);
    tick();

    // Flush coincident with ack: no HOLD, next fetch at new_pc
    drive(0, 6'b000010, 1, 32'h80000200, 0, 0, 1, 32'h33333333);
    check_eq("t4_new", ibus_addr_o, 32'h80000180);
    tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_addr", ibus_addr_o, 32'h80000200);
    check_eq("t5_req", 32'(ibus_req_o), 1);
    check_eq("t5_valid", 32'(inst_valid_o), 0);
    tick();

    // PC wrap from 0xFFFFFFFC to 0
    drive(0, 6'd0, 1, 32'hFFFFFFFC, 0, 0, 1, 0); tick();
    drive(0, 6'd0, 0, 0, 0, 0, 1, 32'h44444444); tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_addr", ibus_addr_o, 32'h00000000);
    tick();

    // Misaligned redirect target
    drive(0, 6'd0, 1, 32'h80000002, 0, 0, 1, 0); tick();
    drive(0, 6'd0, 0, 0, 0, 0, 0, 0);
    if (ADEL) begin
      check_eq("t6_req", 32'(ibus_req_o), 0);
      check_eq("t6_adel", 32'(adel_o), 1);
      check_eq("t6_inst", inst_o, 0);
      check_eq("t6_sreq", 32'(stallreq_o), 0);
    end else begin
      check_eq("t6_addr", ibus_addr_o, 32'h80000000);
      check_eq("t6_adel", 32'(adel_o), 0);
    end
    tick();

    // Randomized phase against the model
    drive(1, 6'd0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3000; i++) begin
      eval_model();
      r   = ($urandom_range(0, 299) == 0);
      hi  = 3'($urandom_range(0, 7));
      st  = {hi, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0)};
      fl  = ($urandom_range(0, 15) == 0);
      npc = rand_addr();
      bf  = ($urandom_range(0, 7) == 0);
      bt  = rand_addr();
      ak  = e_req && ($urandom_range(0, 2) != 0);
      dat = $urandom();
      drive(r, st, fl, npc, bf, bt, ak, dat);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
